gate_op_scheduler: RTL
======================

Name: gate_op_scheduler

Overview:
Round-robin scheduler that shares one mux-based logic-gate evaluation unit among NUM_REQ requesters. Each requester submits an opcode plus operands A and B over a valid/ready handshake. The block grants one request per cycle, evaluates it, and holds the result in a one-entry output register with its own valid/ready handshake. It sits between the gate-test sequencers and the shared gate datapath.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
DATA_W, 1, operand/result width in bits; operations are bitwise
ID_W, 2, width of the requester index; must satisfy 2**ID_W >= NUM_REQ

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
req_valid  input  NUM_REQ  per-requester request valid
req_ready  output  NUM_REQ  per-requester accept; one-hot or zero
req_op  input  3*NUM_REQ  packed opcodes; requester i uses bits [3i+2:3i]
req_a  input  DATA_W*NUM_REQ  packed operand A
req_b  input  DATA_W*NUM_REQ  packed operand B
resp_valid  output  1  result register holds a valid result
resp_ready  input  1  consumer accepts the result
resp_y  output  DATA_W  gate result
resp_id  output  ID_W  index of the requester that produced resp_y
resp_err  output  1  opcode was illegal

Behaviour:
- Opcodes: 0 AND, 1 OR, 2 XOR, 3 NAND, 4 NOR, 5 XNOR, 6 NOT A (B ignored), 7 illegal.
- Opcode 7 -> resp_y = 0, resp_err = 1. All legal opcodes -> resp_err = 0.
- Output slot FSM has two states:
  - EMPTY: resp_valid = 0.
  - FULL: resp_valid = 1.
- can_accept = EMPTY, or (FULL and resp_ready). This allows a same-cycle drain and refill.
- When can_accept and any req_valid is set:
  - grant the first valid requester searching upward from (last_grant+1) mod NUM_REQ.
  - req_ready[grant] = 1 combinationally; all other bits 0.
  - register the result, id and err. The FSM goes to or stays in FULL.
- can_accept with no req_valid:
  - FULL with resp_ready -> EMPTY.
  - EMPTY stays EMPTY.
- FULL without resp_ready:
  - req_ready = 0.
  - resp_y, resp_id and resp_err hold stable.
  - last_grant does not change.
- req_ready never depends on resp_valid of the same requester. It depends only on req_valid, slot state and resp_ready.
- Latency is 1 cycle from the accept edge to resp_valid.
- Throughput is 1 result per cycle when resp_ready is held high.
- last_grant updates only on an accepted grant.
- Fairness: with all NUM_REQ requesters continuously valid, each is granted exactly once in every NUM_REQ consecutive grants.
- A requester that drops req_valid before being granted is skipped. There is no penalty and no stored state for it.
- Reset values (asynchronous, while rst_n = 0):
  - FSM = EMPTY.
  - resp_valid = 0, resp_y = 0, resp_id = 0, resp_err = 0.
  - last_grant = NUM_REQ-1, so requester 0 has first priority after reset.
  - req_ready = 0.
- Reset asserted mid-operation discards any held result. No response is produced for it after reset releases.
- Arithmetic: the round-robin index wraps modulo NUM_REQ. NUM_REQ need not be a power of two.

Optional Feature:
Macro GATE_SCHED_STATS_EN.
- Defined: adds ports stat_clr (input, 1) and stat_grants (output, 16*NUM_REQ).
  - Each requester has a 16-bit saturating grant counter. It increments on each accepted grant and stops at 16'hFFFF.
  - stat_clr zeroes all counters on the next edge. If stat_clr and a grant coincide, the counter becomes 0.
  - Counters reset to 0 on rst_n.
- Undefined: these ports and counters do not exist. All other behaviour is identical.

Test Plan:
1. Reset release, req_valid=4'b0001, op0=0 (AND), a0=1, b0=1, resp_ready=1 -> req_ready=4'b0001; next cycle resp_valid=1, resp_y=1, resp_id=0, resp_err=0.
2. All four requesters valid continuously, resp_ready=1 -> resp_id sequence 0,1,2,3,0,1... with one result per cycle; each requester's ops checked (XOR 1,0 ->1; NOR 0,0 ->1; XNOR 1,0 ->0; NOT A=1 ->0).
3. resp_ready=0 with a result held and 3 requesters valid -> req_ready=0 for 5 cycles, resp_y/resp_id stable; raising resp_ready gives same-cycle drain plus grant to (last_grant+1).
4. op=7 from requester 2, a=1, b=1 -> resp_y=0, resp_err=1, resp_id=2.
5. rst_n pulsed low while FULL and resp_ready=0 -> resp_valid=0 immediately (async); after release requester 0 wins over requester 3 when both are valid.
6. (GATE_SCHED_STATS_EN) 10 grants to requester 1 -> stat_grants[31:16]=10; stat_clr coinciding with a grant -> 0.

Source files
------------

// File: rtl/gate_op_scheduler.sv
// Round-robin scheduler sharing one gate evaluation unit among NUM_REQ requesters,
// with a one-entry result register. Optional grant counters: GATE_SCHED_STATS_EN.
module gate_eval #(
  parameter int DATA_W = 1
) (
  input  logic [2:0]        op,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [DATA_W-1:0] y,
  output logic              err
);
  always_comb begin
    y   = '0;
    err = 1'b0;
    case (op)
      3'd0:    y = a & b;
      3'd1:    y = a | b;
      3'd2:    y = a ^ b;
      3'd3:    y = ~(a & b);
      3'd4:    y = ~(a | b);
      3'd5:    y = ~(a ^ b);
      3'd6:    y = ~a;
      default: err = 1'b1;
    endcase
  end
endmodule

`ifdef GATE_SCHED_STATS_EN
module gate_stat_cnt (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clr,
  input  logic        inc,
  output logic [15:0] cnt
);
  // clr dominates a coincident grant
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                         cnt <= '0;
    else if (clr)                       cnt <= '0;
    else if (inc && cnt != 16'hFFFF)    cnt <= cnt + 16'd1;
  end
endmodule
`endif

module gate_op_scheduler #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 1,
  parameter int ID_W    = 2
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [NUM_REQ-1:0]          req_valid,
  output logic [NUM_REQ-1:0]          req_ready,
  input  logic [3*NUM_REQ-1:0]        req_op,
  input  logic [DATA_W*NUM_REQ-1:0]   req_a,
  input  logic [DATA_W*NUM_REQ-1:0]   req_b,
  output logic                        resp_valid,
  input  logic                        resp_ready,
  output logic [DATA_W-1:0]           resp_y,
  output logic [ID_W-1:0]             resp_id,
  output logic                        resp_err
`ifdef GATE_SCHED_STATS_EN
  ,
  input  logic                        stat_clr,
  output logic [16*NUM_REQ-1:0]       stat_grants
`endif
);
  typedef enum logic {EMPTY, FULL} slot_t;

  slot_t             state, state_nxt;
  logic [ID_W-1:0]   last_grant, gnt_idx, scan;
  logic              gnt_found, can_accept, accept;
  logic [2:0]        sel_op;
  logic [DATA_W-1:0] sel_a, sel_b, eval_y;
  logic              eval_err;

  assign can_accept = (state == EMPTY) || resp_ready;
  assign accept     = rst_n && can_accept && gnt_found;
  assign resp_valid = (state == FULL);

  // Scan upward from last_grant+1 with explicit wrap so NUM_REQ needn't be 2**n
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    scan      = last_grant;
    for (int k = 0; k < NUM_REQ; k++) begin
      scan = (scan == ID_W'(NUM_REQ-1)) ? '0 : scan + 1'b1;
      if (!gnt_found && req_valid[scan]) begin
        gnt_found = 1'b1;
        gnt_idx   = scan;
      end
    end
  end

  always_comb begin
    req_ready = '0;
    sel_op    = '0;
    sel_a     = '0;
    sel_b     = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt_idx == ID_W'(i)) begin
        req_ready[i] = accept;
        sel_op       = req_op[3*i +: 3];
        sel_a        = req_a[DATA_W*i +: DATA_W];
        sel_b        = req_b[DATA_W*i +: DATA_W];
      end
    end
  end

  gate_eval #(.DATA_W(DATA_W)) u_eval (
    .op(sel_op), .a(sel_a), .b(sel_b), .y(eval_y), .err(eval_err)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= EMPTY;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (accept)          state_nxt = FULL;
    else if (can_accept) state_nxt = EMPTY;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      resp_y     <= '0;
      resp_id    <= '0;
      resp_err   <= 1'b0;
      last_grant <= ID_W'(NUM_REQ-1);
    end else if (accept) begin
      resp_y     <= eval_y;
      resp_id    <= gnt_idx;
      resp_err   <= eval_err;
      last_grant <= gnt_idx;
    end
  end

`ifdef GATE_SCHED_STATS_EN
  for (genvar g = 0; g < NUM_REQ; g++) begin : g_stat
    gate_stat_cnt u_cnt (
      .clk(clk), .rst_n(rst_n), .clr(stat_clr), .inc(req_ready[g]),
      .cnt(stat_grants[16*g +: 16])
    );
  end
`endif
endmodule
